// File: rtl/neuro_lut_pkg.sv
// Shared constants and tag types for the neuro_skin activation-LUT sharing block.
// Pure declarations; no logic, no latency, no backpressure.
// Default sizing matches a 4-requester array on an 8-bit LUT.
package neuro_lut_pkg;
  localparam int N_REQ_DEF   = 4;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int LUT_LAT_DEF = 1;
  localparam int ID_W_DEF    = $clog2(N_REQ_DEF);

  typedef logic [ID_W_DEF-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } lut_tag_t;
endpackage

// File: rtl/rr_grant.sv
// One-hot grant over N requesters, round-robin from last+1 (LUT_ARB_FIXED_PRIO_EN: lowest index wins).
// Grant is combinational from req_valid; the round-robin pointer updates on each handshake.
// No backpressure: a valid bit is always eligible, and grants are forced low while rst_n is low.
module rr_grant
  import neuro_lut_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id
);

`ifdef LUT_ARB_FIXED_PRIO_EN
  logic unused_clk;
  assign unused_clk = clk;

  // Scan downward so the lowest asserted index is the one left standing.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        grant_id = IW'(k);
      end
    end
    if (!rst_n) grant = '0;
  end
`else
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
    if (!rst_n) grant = '0;
  end

  // Reset to the top index so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= IW'(N_REQ - 1);
    end else if (|grant) begin
      last <= grant_id;
    end
  end
`endif

endmodule

// File: rtl/lut_share_arbiter.sv
// Shares one registered activation LUT among N_REQ requesters (LUT_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: grant edge -> rsp_valid/rsp_data after LUT_LAT+1 further edges; one lookup per cycle.
// Backpressure only on requests via req_ready; responses are never stalled.
module lut_share_arbiter
  import neuro_lut_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int LUT_LAT = LUT_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    req_ready,
  output logic [AW-1:0]       lut_a,
  input  logic [DW-1:0]       lut_qspo,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0] gnt_id;
  logic          hs;
  tag_t          tag_pipe [LUT_LAT+1];

  rr_grant #(.N_REQ(N_REQ)) u_grant (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .grant    (req_ready),
    .grant_id (gnt_id)
  );

  // A grant is only ever given to a valid requester, so any grant bit is a handshake.
  assign hs = |req_ready;

  // Tags track the LUT pipeline one-for-one and never stall, so the last stage
  // always lines up with the lut_qspo produced for that address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_a     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int s = 0; s <= LUT_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      if (hs) lut_a <= req_addr[gnt_id*AW +: AW];
      tag_pipe[0] <= '{valid: hs, id: gnt_id};
      for (int s = 1; s <= LUT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (tag_pipe[LUT_LAT].valid) begin
        rsp_data  <= lut_qspo;
        rsp_valid <= ONE << tag_pipe[LUT_LAT].id;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lut_share_arbiter.sv
// Directed bench for lut_share_arbiter with a scoreboard on the response bus.
// Grants are checked per cycle; responses are matched for owner, data and arrival cycle.
module tb_lut_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b1111;
  logic [31:0] req_addr = 32'h13121110;
  logic [3:0]  req_ready;
  logic [7:0]  lut_a;
  logic [7:0]  lut_qspo = 8'h00;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] v;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  lut_share_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .lut_a    (lut_a),
    .lut_qspo (lut_qspo),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: one registered stage returning the inverted address.
  always @(posedge clk) lut_qspo <= ~lut_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requests after a rising edge, then check the grant mid-cycle.
  task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] a,
                      input logic [3:0] exp, input bit track);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    req_valid = v;
    req_addr  = a;
    @(negedge clk);
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp});
    if (track && exp != 4'd0) begin
      e.cyc = cyc + 3;
      e.v   = exp;
      e.d   = 8'h00;
      for (int i = 0; i < 4; i++) if (exp[i]) e.d = ~a[i*8 +: 8];
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rsp_valid !== 4'd0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected @cyc %0d: got valid %b data %0h expected none", cyc, rsp_valid, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== e.v || rsp_data !== e.d || cyc != e.cyc) begin
          fails++;
          $display("FAIL rsp @cyc %0d: got valid %b data %0h expected valid %b data %0h at cyc %0d",
                   cyc, rsp_valid, rsp_data, e.v, e.d, e.cyc);
        end
      end
    end
  end

  // Requester obligation: a pending, ungranted request holds valid and address.
  logic [3:0]  pv = 4'd0;
  logic [3:0]  pr = 4'd0;
  logic [31:0] pa = 32'd0;
  logic        prst = 1'b0;
  always @(negedge clk) begin
    if (prst) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i] && (!req_valid[i] || req_addr[i*8 +: 8] != pa[i*8 +: 8])) begin
          tests++;
          fails++;
          $display("FAIL req_stable[%0d] @cyc %0d: got valid %b addr %0h expected valid 1 addr %0h",
                   i, cyc, req_valid[i], req_addr[i*8 +: 8], pa[i*8 +: 8]);
        end
      end
    end
    prst = rst_n;
    pv   = rst_n ? req_valid : 4'd0;
    pr   = req_ready;
    pa   = req_addr;
  end

  localparam logic [31:0] A_C = 32'h13121110;
  localparam logic [31:0] A_W = 32'h00220020;
  localparam logic [31:0] A_S = 32'h005A0000;
  localparam logic [31:0] A_R = 32'h00000700;
  localparam logic [31:0] A_M = 32'h00009900;
  localparam logic [31:0] A_P = 32'h00004140;

  initial begin
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, A_C, 4'b0000, 1'b0);
      mon_en = 1'b1;
      chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
      chk("rst_lut_a", {24'd0, lut_a}, 32'd0);
    end

`ifdef LUT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, A_C, 4'b0010, 1'b1);
    step(1'b1, 4'b1000, A_C, 4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, A_C, 4'b0000, 1'b0);
`else
    begin
      logic [3:0] cv [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      logic [3:0] ce [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [3:0] wv [4] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100};
      logic [3:0] we [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      for (int i = 0; i < 8; i++) step(1'b1, cv[i], A_C, ce[i], 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, wv[i], A_W, we[i], 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, A_W, 4'b0000, 1'b0);

    step(1'b1, 4'b0100, A_S, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, A_S, 4'b0000, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, A_R, 4'b0010, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, A_R, 4'b0000, 1'b0);

    step(1'b1, 4'b0010, A_M, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, A_M, 4'b0000, 1'b0);
    chk("midflight_rsp", {28'd0, rsp_valid}, 32'd0);
    step(1'b0, 4'b0000, A_M, 4'b0000, 1'b0);
    chk("midflight_rsp", {28'd0, rsp_valid}, 32'd0);
    step(1'b1, 4'b0011, A_P, 4'b0001, 1'b1);
    chk("midflight_rsp", {28'd0, rsp_valid}, 32'd0);
    step(1'b1, 4'b0010, A_P, 4'b0010, 1'b1);
    chk("midflight_rsp", {28'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, A_P, 4'b0000, 1'b0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
